store_commit_buffer: RTL and testbench

Buffers committed store writes from the reorder buffer's memory-commit port (`we_mem`/`ws_mem`/`wd_mem`) and drains them, oldest first, into the data cache write port. On a cache write miss the store goes to data memory over a request/acknowledge handshake. The reorder buffer can therefore retire a store in one cycle without stalling on cache misses. The block sits between the reorder buffer commit stage and `data_cache`/`data_memory`.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/store_commit_buffer_if.sv | 50 +++++
 rtl/sbuf_fifo.sv | 84 ++++++++
 rtl/store_commit_buffer.sv | 145 ++++++++++++++
 tb/tb_store_commit_buffer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the store commit buffer: data width,
// store-buffer FSM states and the buffered store entry layout.
package cpu_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_CACHE = 2'd1,
    SB_MEM   = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bus bundle of the store commit buffer: commit port from the reorder
// buffer, status flags, data cache write port and data memory handshake.
// The forwarding lookup signals exist only when STORE_FWD_EN is defined.
interface store_commit_buffer_if;
  import cpu_pkg::*;

  logic                 we_mem;
  logic [WORD_SIZE-1:0] ws_mem;
  logic [WORD_SIZE-1:0] wd_mem;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic [WORD_SIZE-1:0] cache_ptr_write;
  logic [WORD_SIZE-1:0] cache_val;
  logic                 cache_write_enable;
  logic                 cache_hit_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_we;
  logic                 mem_ack;
`ifdef STORE_FWD_EN
  logic                 fwd_req;
  logic [WORD_SIZE-1:0] fwd_addr;
  logic                 fwd_hit;
  logic [WORD_SIZE-1:0] fwd_data;
`endif

  // Buffer side
  modport slave (
    input  we_mem, ws_mem, wd_mem, cache_hit_write, mem_ack,
`ifdef STORE_FWD_EN
    input  fwd_req, fwd_addr,
    output fwd_hit, fwd_data,
`endif
    output full, empty, overflow, cache_ptr_write, cache_val,
    output cache_write_enable, mem_addr, mem_data, mem_we
  );

  // Reorder buffer / cache / memory side
  modport master (
    output we_mem, ws_mem, wd_mem, cache_hit_write, mem_ack,
`ifdef STORE_FWD_EN
    output fwd_req, fwd_addr,
    input  fwd_hit, fwd_data,
`endif
    input  full, empty, overflow, cache_ptr_write, cache_val,
    input  cache_write_enable, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/sbuf_fifo.sv
// Circular store FIFO: storage, head/tail pointers, occupancy count,
// full flag and sticky overflow. A push arriving while full is dropped
// even when a pop happens on the same edge.
module sbuf_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  sb_entry_t push_entry,
  input  logic      pop,
  output sb_entry_t head_entry,
  output logic [PW:0] count,
  output logic      full,
  output logic      overflow
`ifdef STORE_FWD_EN
  ,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [PW-1:0]         head_ptr
`endif
);

  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  sb_entry_t [DEPTH-1:0] mem_r;
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [PW:0]           count_r;
  logic                  overflow_r;
  logic                  full_s;
  logic                  accept_s;

  assign full_s   = (count_r == CNT_FULL);
  assign accept_s = push & ~full_s;

  // Write accepted stores at the tail slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r <= '0;
    end else if (accept_s) begin
      mem_r[tail_r] <= push_entry;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop) begin
        head_r <= head_r + PTR_ONE;
      end
      if (push & full_s) begin
        overflow_r <= 1'b1;
      end
      case ({accept_s, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_entry = mem_r[head_r];
  assign count      = count_r;
  assign full       = full_s;
  assign overflow   = overflow_r;
`ifdef STORE_FWD_EN
  assign entries    = mem_r;
  assign head_ptr   = head_r;
`endif

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: accepts committed stores from the reorder buffer and
// drains them oldest first into the data cache, falling back to a
// write-around memory write on a cache miss.
// Optional feature macro: STORE_FWD_EN adds a store-to-load forwarding lookup.
module store_commit_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  store_commit_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);

  sb_state_t   state_r;
  logic        cache_we_r;
  logic        mem_we_r;
  sb_entry_t   head_s;
  sb_entry_t   push_entry_s;
  logic [PW:0] count_s;
  logic        full_s;
  logic        overflow_s;
  logic        push_ok_s;
  logic        pop_s;
  logic        remain_s;
`ifdef STORE_FWD_EN
  sb_entry_t [DEPTH-1:0] entries_s;
  logic [PW-1:0]         head_ptr_s;
  logic                  fwd_hit_s;
  logic [WORD_SIZE-1:0]  fwd_data_s;
`endif

  assign push_entry_s = '{addr: bus.ws_mem, data: bus.wd_mem};
  assign push_ok_s    = bus.we_mem & ~full_s;
  // After a pop the buffer still holds work if more than one entry was
  // queued or a new store lands on the same edge.
  assign remain_s     = (count_s > CNT_ONE) | push_ok_s;

  sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.we_mem),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_entry (head_s),
    .count      (count_s),
    .full       (full_s),
    .overflow   (overflow_s)
`ifdef STORE_FWD_EN
    ,
    .entries    (entries_s),
    .head_ptr   (head_ptr_s)
`endif
  );

  // Retire the head on a cache hit or an acknowledged memory write
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      SB_CACHE: pop_s = bus.cache_hit_write;
      SB_MEM:   pop_s = bus.mem_ack;
      default:  pop_s = 1'b0;
    endcase
  end

  // Drain FSM with registered cache/memory write strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= SB_IDLE;
      cache_we_r <= 1'b0;
      mem_we_r   <= 1'b0;
    end else begin
      case (state_r)
        SB_IDLE: begin
          if (count_s != '0) begin
            state_r    <= SB_CACHE;
            cache_we_r <= 1'b1;
          end
        end
        SB_CACHE: begin
          if (bus.cache_hit_write) begin
            if (remain_s) begin
              state_r    <= SB_CACHE;
              cache_we_r <= 1'b1;
            end else begin
              state_r    <= SB_IDLE;
              cache_we_r <= 1'b0;
            end
          end else begin
            state_r    <= SB_MEM;
            cache_we_r <= 1'b0;
            mem_we_r   <= 1'b1;
          end
        end
        SB_MEM: begin
          if (bus.mem_ack) begin
            state_r  <= SB_IDLE;
            mem_we_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= SB_IDLE;
          cache_we_r <= 1'b0;
          mem_we_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full               = full_s;
  assign bus.overflow           = overflow_s;
  assign bus.empty              = (count_s == '0) && (state_r == SB_IDLE);
  assign bus.cache_write_enable = cache_we_r;
  assign bus.mem_we             = mem_we_r;
  assign bus.cache_ptr_write    = head_s.addr;
  assign bus.cache_val          = head_s.data;
  assign bus.mem_addr           = head_s.addr;
  assign bus.mem_data           = head_s.data;

`ifdef STORE_FWD_EN
  // Search valid entries oldest to youngest so the youngest match wins
  always_comb begin : fwd_lookup
    logic [PW-1:0] idx;
    logic          match;
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    idx        = '0;
    match      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx        = head_ptr_s + PW'(i);
      match      = bus.fwd_req && ((PW+1)'(i) < count_s) &&
                   (entries_s[idx].addr == bus.fwd_addr);
      fwd_hit_s  = fwd_hit_s | match;
      fwd_data_s = match ? entries_s[idx].data : fwd_data_s;
    end
  end

  assign bus.fwd_hit  = fwd_hit_s;
  assign bus.fwd_data = fwd_data_s;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_commit_buffer;
  import cpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int M_IDLE  = 0;
  localparam int M_CACHE = 1;
  localparam int M_MEM   = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  store_commit_buffer_if bus();

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  sb_entry_t   mq[$];
  int          phase;
  bit          m_ovf;
  logic [31:0] retired[$];
  int          mem_we_cycles;
  int          cache_we_cycles;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    phase = M_IDLE;
    m_ovf = 1'b0;
  endtask

`ifdef STORE_FWD_EN
  task automatic model_fwd(input logic req, input logic [31:0] a,
                           output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'h0;
    if (req) begin
      foreach (mq[i]) begin
        if (mq[i].addr == a) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
    end
  endtask
`endif

  task automatic check_outputs();
`ifdef STORE_FWD_EN
    logic        fh;
    logic [31:0] fd;
`endif
    check_val("full", bus.full, 32'(mq.size() == DEPTH));
    check_val("empty", bus.empty, 32'(mq.size() == 0 && phase == M_IDLE));
    check_val("overflow", bus.overflow, 32'(m_ovf));
    check_val("cache_write_enable", bus.cache_write_enable, 32'(phase == M_CACHE));
    check_val("mem_we", bus.mem_we, 32'(phase == M_MEM));
    if (phase == M_CACHE && mq.size() > 0) begin
      check_val("cache_ptr_write", bus.cache_ptr_write, mq[0].addr);
      check_val("cache_val", bus.cache_val, mq[0].data);
    end
    if (phase == M_MEM && mq.size() > 0) begin
      check_val("mem_addr", bus.mem_addr, mq[0].addr);
      check_val("mem_data", bus.mem_data, mq[0].data);
    end
`ifdef STORE_FWD_EN
    model_fwd(bus.fwd_req, bus.fwd_addr, fh, fd);
    check_val("fwd_hit", bus.fwd_hit, 32'(fh));
    check_val("fwd_data", bus.fwd_data, fd);
`endif
  endtask

  // One clock cycle: check at negedge, drive, advance model at posedge.
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit hit, input bit ack);
    int        sz;
    bit        push_ok;
    bit        pop;
    int        nphase;
    sb_entry_t e;
    check_outputs();
    if (bus.mem_we) mem_we_cycles++;
    if (bus.cache_write_enable) cache_we_cycles++;
    if (bus.cache_write_enable && hit) retired.push_back(bus.cache_ptr_write);
    else if (bus.mem_we && ack) retired.push_back(bus.mem_addr);
    bus.we_mem          = we;
    bus.ws_mem          = a;
    bus.wd_mem          = d;
    bus.cache_hit_write = hit;
    bus.mem_ack         = ack;
`ifdef STORE_FWD_EN
    bus.fwd_req  = ($urandom_range(0, 3) != 0);
    bus.fwd_addr = 32'($urandom_range(0, 7)) * 32'd4;
`endif
    @(posedge clk);
    sz      = mq.size();
    push_ok = we && (sz < DEPTH);
    pop     = 1'b0;
    nphase  = phase;
    if (we && !push_ok) m_ovf = 1'b1;
    case (phase)
      M_IDLE:  if (sz > 0) nphase = M_CACHE;
      M_CACHE: begin
        if (hit) begin
          pop    = 1'b1;
          nphase = ((sz - 1 + int'(push_ok)) > 0) ? M_CACHE : M_IDLE;
        end else begin
          nphase = M_MEM;
        end
      end
      M_MEM: if (ack) begin
        pop    = 1'b1;
        nphase = M_IDLE;
      end
      default: nphase = M_IDLE;
    endcase
    if (pop) void'(mq.pop_front());
    if (push_ok) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
    end
    phase = nphase;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.we_mem          = 1'b0;
    bus.ws_mem          = 32'h0;
    bus.wd_mem          = 32'h0;
    bus.cache_hit_write = 1'b0;
    bus.mem_ack         = 1'b0;
`ifdef STORE_FWD_EN
    bus.fwd_req  = 1'b0;
    bus.fwd_addr = 32'h0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check_val("rst_full", bus.full, 32'd0);
    check_val("rst_empty", bus.empty, 32'd1);
    check_val("rst_overflow", bus.overflow, 32'd0);
    check_val("rst_cache_we", bus.cache_write_enable, 32'd0);
    check_val("rst_mem_we", bus.mem_we, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_clear();
    apply_reset();

    // single store, cache hit
    step(1'b1, 32'h10, 32'hAA, 1'b1, 1'b0);
    check_val("hit_e0_cwe", bus.cache_write_enable, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("hit_e1_cwe", bus.cache_write_enable, 32'd1);
    check_val("hit_e1_addr", bus.cache_ptr_write, 32'h10);
    check_val("hit_e1_data", bus.cache_val, 32'hAA);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("hit_e2_cwe", bus.cache_write_enable, 32'd0);
    check_val("hit_e2_empty", bus.empty, 32'd1);

    // single store, cache miss, ack three cycles after MEM entry
    step(1'b1, 32'h20, 32'hBB, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_val("miss_mem_we", bus.mem_we, 32'd1);
    check_val("miss_mem_addr", bus.mem_addr, 32'h20);
    check_val("miss_mem_data", bus.mem_data, 32'hBB);
    mem_we_cycles = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_val("miss_mem_we_cycles", 32'(mem_we_cycles), 32'd4);
    check_val("miss_empty", bus.empty, 32'd1);

    // fill and overflow, then drain in order
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      if (i == 4) check_val("fill_full", bus.full, 32'd1);
    end
    check_val("fill_overflow", bus.overflow, 32'd1);
    retired.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check_val("drain_count", 32'(retired.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < retired.size()) check_val("drain_order", retired[i], 32'(i + 1));
    end

    // wrap-around: a push every cycle, all hits
    apply_reset();
    retired.delete();
    cache_we_cycles = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i), 32'h200 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("wrap_count", 32'(retired.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < retired.size()) check_val("wrap_order", retired[i], 32'(i));
    end
    check_val("wrap_cwe_cycles", 32'(cache_we_cycles), 32'd6);
    check_val("wrap_overflow", bus.overflow, 32'd0);

    // reset while in MEM holding three entries
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i), 32'h300, 1'b0, 1'b0);
    check_val("pre_rst_mem_we", bus.mem_we, 32'd1);
    reset = 1'b0;
    #1;
    check_val("midrst_mem_we", bus.mem_we, 32'd0);
    check_val("midrst_empty", bus.empty, 32'd1);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_val("postrst_empty", bus.empty, 32'd1);

`ifdef STORE_FWD_EN
    // forwarding: youngest matching entry wins
    step(1'b1, 32'h40, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h40, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h44, 32'h3, 1'b0, 1'b0);
    bus.fwd_req  = 1'b1;
    bus.fwd_addr = 32'h40;
    #1;
    check_val("fwd40_hit", bus.fwd_hit, 32'd1);
    check_val("fwd40_data", bus.fwd_data, 32'h2);
    bus.fwd_addr = 32'h48;
    #1;
    check_val("fwd48_hit", bus.fwd_hit, 32'd0);
    check_val("fwd48_data", bus.fwd_data, 32'h0);
    apply_reset();
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 55),
           32'($urandom_range(0, 7)) * 32'd4,
           32'($urandom),
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 35));
      if (i == 250) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
